led_pattern_sequencer: RTL and testbench

LED_PATTERN_SEQUENCER -- requirements
Module: led_pattern_sequencer

---
 rtl/led_pattern_sequencer.sv | 124 ++++++++++++
 tb/tb_led_pattern_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
//   Steps an LED pattern once every PERIOD enabled clock cycles. Four modes:
//   rotate-left, rotate-right, bounce (a single lit LED moving back and forth)
//   and fill/drain (shift ones in until full, then shift zeros in until empty).
//
//   Optional feature: define LED_BOUNCE_EN to build the bounce logic. When it is
//   undefined, mode 2'b10 behaves as rotate-left.
//
// Parameters
//   WIDTH    LED count (>= 2)
//   PERIOD   enabled clk cycles per pattern step (>= 1)
//   CNT_W    prescaler width; must hold PERIOD-1
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset (led=1, prescaler=0, dir=left)
//   en        in   prescaler/step enable
//   mode      in   00 rotl, 01 rotr, 10 bounce, 11 fill/drain
//   load      in   synchronous load; beats a same-cycle tick
//   load_val  in   pattern for load
//   led       out  registered LED pattern
//   step      out  registered one-cycle pulse after each pattern step
module led_pattern_sequencer #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned PERIOD = 50000000,
  parameter int unsigned CNT_W  = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] led,
  output logic             step
);

  typedef enum logic {DirLeft, DirRight} dir_e;

  localparam logic [CNT_W-1:0] LastCnt  = CNT_W'(PERIOD - 1);
  localparam logic [WIDTH-1:0] ResetLed = WIDTH'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] led_q, led_d;
  dir_e             dir_q, dir_d;
  logic             step_q, step_d;
  logic             tick;
  logic [WIDTH-1:0] fill_val;

  assign tick = en && (cnt_q == LastCnt);

  // Fill shifts in a one while heading left, a zero while heading right.
  assign fill_val = {led_q[WIDTH-2:0], (dir_q == DirLeft)};

  always_comb begin
    cnt_d  = cnt_q;
    led_d  = led_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    if (load) begin
      cnt_d = '0;
      led_d = load_val;
      dir_d = DirLeft;
    end else if (en) begin
      if (tick) begin
        cnt_d  = '0;
        step_d = 1'b1;
        case (mode)
          2'b00: led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
          2'b01: led_d = {led_q[0], led_q[WIDTH-1:1]};
          2'b10: begin
`ifdef LED_BOUNCE_EN
            if (dir_q == DirLeft) begin
              if (led_q[WIDTH-1]) begin
                dir_d = DirRight;
                led_d = led_q >> 1;
              end else begin
                led_d = led_q << 1;
              end
            end else begin
              if (led_q[0]) begin
                dir_d = DirLeft;
                led_d = led_q << 1;
              end else begin
                led_d = led_q >> 1;
              end
            end
`else
            led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
`endif
          end
          2'b11: begin
            led_d = fill_val;
            if (&fill_val) begin
              dir_d = DirRight;
            end else if (fill_val == '0) begin
              dir_d = DirLeft;
            end
          end
          default: led_d = led_q;
        endcase
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      led_q  <= ResetLed;
      dir_q  <= DirLeft;
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      led_q  <= led_d;
      dir_q  <= dir_d;
      step_q <= step_d;
    end
  end

  assign led  = led_q;
  assign step = step_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer (WIDTH=8, PERIOD=4).
module tb_led_pattern_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] led;
  logic       step;

  int n_checks = 0;
  int n_pass   = 0;

  led_pattern_sequencer #(
    .WIDTH (8),
    .PERIOD(4),
    .CNT_W (27)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .load    (load),
    .load_val(load_val),
    .led     (led),
    .step    (step)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] val;
    logic [7:0] e0;
    logic [7:0] e1;
    logic [7:0] e2;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Wait for the next step pulse; returns edges taken (20 means timed out).
  task automatic wait_step(output int cycles);
    cycles = 0;
    do begin
      cyc();
      cycles++;
    end while (!step && cycles < 20);
  endtask

  task automatic do_load(input logic [1:0] m, input logic [7:0] v);
    mode     = m;
    load_val = v;
    load     = 1'b1;
    en       = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    int cycles;
    logic [7:0] fill_seq[17];
    logic [7:0] exp_v;
    logic ok;

    vecs[0] = '{2'b00, 8'h01, 8'h02, 8'h04, 8'h08};
    vecs[1] = '{2'b01, 8'h01, 8'h80, 8'h40, 8'h20};
    vecs[2] = '{2'b11, 8'h00, 8'h01, 8'h03, 8'h07};
`ifdef LED_BOUNCE_EN
    vecs[3] = '{2'b10, 8'h80, 8'h40, 8'h20, 8'h10};
    vecs[6] = '{2'b10, 8'h40, 8'h80, 8'h40, 8'h20};
`else
    vecs[3] = '{2'b10, 8'h80, 8'h01, 8'h02, 8'h04};
    vecs[6] = '{2'b10, 8'h40, 8'h80, 8'h01, 8'h02};
`endif
    vecs[4] = '{2'b00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[5] = '{2'b01, 8'hA5, 8'hD2, 8'h69, 8'hB4};

    fill_seq = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h01};

    rst = 1'b1; en = 1'b0; mode = 2'b00; load = 1'b0; load_val = 8'h00;
    #1;
    chk("reset_led", 32'(led), 32'h01);
    chk("reset_step", 32'(step), 32'h0);
    cyc();
    cyc();
    rst = 1'b0;
    en  = 1'b1;

    // Rotate-left from reset, one step every 4 cycles.
    exp_v = 8'h01;
    for (int i = 0; i < 8; i++) begin
      exp_v = {exp_v[6:0], exp_v[7]};
      wait_step(cycles);
      chk($sformatf("rotl_period_%0d", i), 32'(cycles), 32'd4);
      chk($sformatf("rotl_led_%0d", i), 32'(led), 32'(exp_v));
    end
    cyc();
    chk("step_one_cycle", 32'(step), 32'h0);

    // Table of load + three steps.
    foreach (vecs[k]) begin
      do_load(vecs[k].mode, vecs[k].val);
      chk($sformatf("v%0d_load", k), 32'(led), 32'(vecs[k].val));
      chk($sformatf("v%0d_load_nostep", k), 32'(step), 32'h0);
      wait_step(cycles);
      chk($sformatf("v%0d_s0", k), 32'(led), 32'(vecs[k].e0));
      wait_step(cycles);
      chk($sformatf("v%0d_s1", k), 32'(led), 32'(vecs[k].e1));
      wait_step(cycles);
      chk($sformatf("v%0d_s2", k), 32'(led), 32'(vecs[k].e2));
      chk($sformatf("v%0d_period", k), 32'(cycles), 32'd4);
    end

`ifdef LED_BOUNCE_EN
    // Bounce reversing at the LSB: reach 0x02 heading right, then 0x01, 0x02.
    do_load(2'b10, 8'h80);
    wait_step(cycles);
    for (int i = 0; i < 5; i++) wait_step(cycles);
    chk("bounce_r_02", 32'(led), 32'h02);
    wait_step(cycles);
    chk("bounce_r_01", 32'(led), 32'h01);
    wait_step(cycles);
    chk("bounce_r_back", 32'(led), 32'h02);
`endif

    // Full fill/drain cycle.
    do_load(2'b11, 8'h00);
    for (int i = 0; i < 17; i++) begin
      wait_step(cycles);
      chk($sformatf("fill_%0d", i), 32'(led), 32'(fill_seq[i]));
    end

    // en held low mid-count: no change, count resumes from held value.
    do_load(2'b00, 8'h01);
    cyc();
    cyc();
    en = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (led !== 8'h01 || step !== 1'b0) ok = 1'b0;
    end
    chk("hold_no_change", 32'(ok), 32'h1);
    en = 1'b1;
    wait_step(cycles);
    chk("hold_resume_cycles", 32'(cycles), 32'd2);
    chk("hold_resume_led", 32'(led), 32'h02);

    // Load on the tick edge wins.
    do_load(2'b00, 8'h01);
    cyc();
    cyc();
    cyc();
    load_val = 8'h5A;
    load     = 1'b1;
    cyc();
    load = 1'b0;
    chk("load_tick_led", 32'(led), 32'h5A);
    chk("load_tick_nostep", 32'(step), 32'h0);
    cyc();
    chk("load_tick_nostep2", 32'(step), 32'h0);
    wait_step(cycles);
    chk("load_tick_next_cycles", 32'(cycles), 32'd3);
    chk("load_tick_next_led", 32'(led), 32'hB4);

    // en dropping right after the tick edge: tick already happened.
    do_load(2'b00, 8'h01);
    cyc();
    cyc();
    cyc();
    cyc();
    en = 1'b0;
    chk("en_fall_step", 32'(step), 32'h1);
    chk("en_fall_led", 32'(led), 32'h02);
    cyc();
    chk("en_fall_step_clear", 32'(step), 32'h0);

    // Asynchronous reset between edges, mid-count.
    en = 1'b1;
    do_load(2'b00, 8'h3C);
    cyc();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_led", 32'(led), 32'h01);
    chk("async_rst_step", 32'(step), 32'h0);
    #1 rst = 1'b0;
    wait_step(cycles);
    chk("rst_restart_cycles", 32'(cycles), 32'd4);
    chk("rst_restart_led", 32'(led), 32'h02);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
